// File: rtl/fetch_pkg.sv
// Shared widths, default queue depth and the fetch FSM state encoding.
package fetch_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush empties it and wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clka,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer, occupancy and storage update; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= din;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = storage[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: one outstanding memory read at a time, results
// buffered with their PCs in a prefetch FIFO and drained by decode.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   FETCH   | request fetch_pc whenever the queue has room
//   WAIT    | request granted, waiting for rvalid to push the word
//   DISCARD | request granted but redirected away; drop its response
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clka,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  fetch_state_t               state;
  fetch_state_t               state_nxt;
  logic [PC_W-1:0]            fetch_pc;
  logic [PC_W-1:0]            req_pc;
  logic [CW-1:0]              count;
  logic [PC_W+INSTR_W-1:0]    head;
  logic                       push;
  logic                       pop;
  logic                       gnt_ok;

  assign gnt_ok   = mem_req & mem_gnt;
  assign mem_addr = fetch_pc;
  assign id_valid = (count != '0) & ~redirect;
  assign pop      = id_valid & id_ready;
  assign {id_pc, id_instr} = head;

  // State register.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next state, request and push; mem_req is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    push      = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = rst_n & (count < FULL);
        if (mem_req & mem_gnt) state_nxt = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        push = mem_rvalid & ~redirect;
        if (mem_rvalid)    state_nxt = FETCH;
        else if (redirect) state_nxt = DISCARD;
      end
      DISCARD: begin
        if (mem_rvalid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Fetch PC walk and capture of the PC belonging to the outstanding request.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC & ALIGN_MASK;
      req_pc   <= '0;
    end else begin
      if (gnt_ok) req_pc <= fetch_pc;
      if (redirect)    fetch_pc <= redirect_pc & ALIGN_MASK;
      else if (gnt_ok) fetch_pc <= fetch_pc + PC_W'(4);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INSTR_W)
  ) u_fifo (
    .clka  (clka),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({req_pc, mem_rdata}),
    .count (count),
    .head  (head)
  );

endmodule
